// File: rtl/mem_wrap_pkg.sv
// mem_wrap_pkg: shared types and constants for the mem_wrap memory subsystem.
//   port_state_e         - per-port handshake FSM state
//   MMIO_WORD_FROM_TOP   - console/exit register position, counted in words from the top of the data space
//   is_legal_instr_width - fetch-width legality check used at elaboration
package mem_wrap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  // The device register occupies the last word of the data address space
  localparam int unsigned MMIO_WORD_FROM_TOP = 1;

  function automatic bit is_legal_instr_width(input int unsigned w);
    return (w == 32) || (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/mem_wrap_port.sv
// mem_wrap_port: request/grant/rvalid handshake for one memory port.
// Holds at most one outstanding request. The read data presented on i_rdata
// in the accept cycle is captured and returned LATENCY cycles later.
//   i_clk, i_rstn   clock, synchronous active-low reset
//   i_req / o_gnt   request, combinational grant (0 during reset)
//   i_rdata         data to return for the request being accepted this cycle
//   o_rvalid        one-cycle response strobe
//   o_rdata         response data, 0 outside o_rvalid cycles
module mem_wrap_port
  import mem_wrap_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int          LATENCY = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_req,
  output logic             o_gnt,
  input  logic [WIDTH-1:0] i_rdata,
  output logic             o_rvalid,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("mem_wrap_port: LATENCY must be at least 1");
  end

  port_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             w_accept;

  // A new request can be taken while idle or while the previous response is going out
  assign o_gnt    = i_rstn & i_req & ((r_state == ST_IDLE) | (r_state == ST_RESP));
  assign w_accept = o_gnt;

  // Handshake FSM with latency counter and response register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      if (w_accept) begin
        r_hold <= i_rdata;
        r_cnt  <= CNT_W'(LATENCY - 1);
        if (LATENCY == 1) begin
          r_state  <= ST_RESP;
          r_rvalid <= 1'b1;
          r_rdata  <= i_rdata;
        end else begin
          r_state <= ST_WAIT;
        end
      end else begin
        case (r_state)
          ST_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
              r_state  <= ST_RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= r_hold;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/mem_wrap.sv
// mem_wrap: single-clock memory with an instruction fetch port and a data port
// sharing one 32-bit word array of 2**(ADDR_WIDTH-2) entries.
//   clk_i, rstn_i                          clock, synchronous active-low reset
//   instr_req_i/gnt_o/rvalid_o/addr_i      fetch handshake and byte address
//   instr_rdata_o                          INSTR_RDATA_WIDTH/32 aligned words, lowest in [31:0]
//   data_req_i/gnt_o/rvalid_o/addr_i       data handshake and byte address
//   data_we_i, data_be_i, data_wdata_i     write strobe, byte enables, write data
//   data_rdata_o                           read data (0 for writes)
//   mmio_wvalid_o, mmio_wdata_o            console character strobe and value
//   mmio_exit_o                            sticky exit flag
// Optional feature macro: MEM_MMIO_EN maps the last data word to the console/exit
// register; when undefined that word is RAM and the mmio outputs are 0.
module mem_wrap
  import mem_wrap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 22,
  parameter int unsigned INSTR_RDATA_WIDTH = 128,
  parameter int          INSTR_LATENCY     = 1,
  parameter int          DATA_LATENCY      = 1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         instr_req_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]        instr_addr_i,
  output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
  input  logic                         data_req_i,
  output logic                         data_gnt_o,
  output logic                         data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]        data_addr_i,
  input  logic                         data_we_i,
  input  logic [3:0]                   data_be_i,
  input  logic [31:0]                  data_wdata_i,
  output logic [31:0]                  data_rdata_o,
  output logic                         mmio_wvalid_o,
  output logic [7:0]                   mmio_wdata_o,
  output logic                         mmio_exit_o
);

  localparam int unsigned WORD_AW     = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH       = 1 << WORD_AW;
  localparam int unsigned FETCH_WORDS = INSTR_RDATA_WIDTH / 32;

  if (!is_legal_instr_width(INSTR_RDATA_WIDTH)) begin : g_bad_width
    $error("mem_wrap: INSTR_RDATA_WIDTH must be 32, 64 or 128");
  end

  logic [31:0]                  r_mem [DEPTH];
  logic [WORD_AW-1:0]           w_fetch_base;
  logic [WORD_AW-1:0]           w_data_word;
  logic [INSTR_RDATA_WIDTH-1:0] w_fetch_rdata;
  logic [31:0]                  w_data_rdata;
  logic                         w_data_acc;
  logic                         w_is_mmio;
  logic                         w_unused;

  // Byte-offset bits below word granularity carry no information here
  assign w_unused = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  // Fetch: align down to the fetch width and gather consecutive words
  assign w_fetch_base = instr_addr_i[ADDR_WIDTH-1:2] & ~WORD_AW'(FETCH_WORDS - 1);

  always_comb begin
    w_fetch_rdata = '0;
    for (int unsigned k = 0; k < FETCH_WORDS; k++) begin
      w_fetch_rdata[32*k +: 32] = r_mem[w_fetch_base | WORD_AW'(k)];
    end
  end

  // Data: writes return 0, as does the device register
  assign w_data_word  = data_addr_i[ADDR_WIDTH-1:2];
  assign w_data_acc   = data_req_i & data_gnt_o;
  assign w_data_rdata = (data_we_i | w_is_mmio) ? 32'h0 : r_mem[w_data_word];

  // Byte-lane writes land at the end of the accept cycle, after any same-cycle fetch sample
  always_ff @(posedge clk_i) begin
    if (w_data_acc && data_we_i && !w_is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          r_mem[w_data_word][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

`ifdef MEM_MMIO_EN
  logic r_exit;

  assign w_is_mmio     = (w_data_word == WORD_AW'(DEPTH - MMIO_WORD_FROM_TOP));
  assign mmio_wvalid_o = w_data_acc & data_we_i & w_is_mmio & data_be_i[0];
  assign mmio_wdata_o  = mmio_wvalid_o ? data_wdata_i[7:0] : 8'h00;

  // Exit flag stays set until reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_exit <= 1'b0;
    end else if (w_data_acc && data_we_i && w_is_mmio && data_be_i[1] && data_wdata_i[8]) begin
      r_exit <= 1'b1;
    end
  end

  assign mmio_exit_o = r_exit;
`else
  assign w_is_mmio     = 1'b0;
  assign mmio_wvalid_o = 1'b0;
  assign mmio_wdata_o  = 8'h00;
  assign mmio_exit_o   = 1'b0;
`endif

  mem_wrap_port #(
    .WIDTH   (INSTR_RDATA_WIDTH),
    .LATENCY (INSTR_LATENCY)
  ) u_instr_port (
    .i_clk    (clk_i),
    .i_rstn   (rstn_i),
    .i_req    (instr_req_i),
    .o_gnt    (instr_gnt_o),
    .i_rdata  (w_fetch_rdata),
    .o_rvalid (instr_rvalid_o),
    .o_rdata  (instr_rdata_o)
  );

  mem_wrap_port #(
    .WIDTH   (32),
    .LATENCY (DATA_LATENCY)
  ) u_data_port (
    .i_clk    (clk_i),
    .i_rstn   (rstn_i),
    .i_req    (data_req_i),
    .o_gnt    (data_gnt_o),
    .i_rdata  (w_data_rdata),
    .o_rvalid (data_rvalid_o),
    .o_rdata  (data_rdata_o)
  );

endmodule

// File: tb/tb_mem_wrap.sv
// tb_mem_wrap: directed self-checking bench for mem_wrap.
// Instance A uses the default parameters (128-bit fetch, latency 1 on both ports);
// instance B uses a 32-bit fetch, INSTR_LATENCY=4 and DATA_LATENCY=3.
module tb_mem_wrap;

  localparam int unsigned AW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A signals
  logic          a_rstn, a_ireq, a_igt, a_irv, a_dreq, a_dgnt, a_drv, a_dwe, a_mv, a_mx;
  logic [AW-1:0] a_iaddr, a_daddr;
  logic [127:0]  a_ird;
  logic [3:0]    a_dbe;
  logic [31:0]   a_dwd, a_drd;
  logic [7:0]    a_md;

  // Instance B signals
  logic          b_rstn, b_ireq, b_igt, b_irv, b_dreq, b_dgnt, b_drv, b_dwe, b_mv, b_mx;
  logic [AW-1:0] b_iaddr, b_daddr;
  logic [31:0]   b_ird;
  logic [3:0]    b_dbe;
  logic [31:0]   b_dwd, b_drd;
  logic [7:0]    b_md;

  mem_wrap u_dut_a (
    .clk_i (clk), .rstn_i (a_rstn),
    .instr_req_i (a_ireq), .instr_gnt_o (a_igt), .instr_rvalid_o (a_irv),
    .instr_addr_i (a_iaddr), .instr_rdata_o (a_ird),
    .data_req_i (a_dreq), .data_gnt_o (a_dgnt), .data_rvalid_o (a_drv),
    .data_addr_i (a_daddr), .data_we_i (a_dwe), .data_be_i (a_dbe),
    .data_wdata_i (a_dwd), .data_rdata_o (a_drd),
    .mmio_wvalid_o (a_mv), .mmio_wdata_o (a_md), .mmio_exit_o (a_mx)
  );

  mem_wrap #(
    .ADDR_WIDTH (AW), .INSTR_RDATA_WIDTH (32), .INSTR_LATENCY (4), .DATA_LATENCY (3)
  ) u_dut_b (
    .clk_i (clk), .rstn_i (b_rstn),
    .instr_req_i (b_ireq), .instr_gnt_o (b_igt), .instr_rvalid_o (b_irv),
    .instr_addr_i (b_iaddr), .instr_rdata_o (b_ird),
    .data_req_i (b_dreq), .data_gnt_o (b_dgnt), .data_rvalid_o (b_drv),
    .data_addr_i (b_daddr), .data_we_i (b_dwe), .data_be_i (b_dbe),
    .data_wdata_i (b_dwd), .data_rdata_o (b_drd),
    .mmio_wvalid_o (b_mv), .mmio_wdata_o (b_md), .mmio_exit_o (b_mx)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One data transaction on A; latency 1 means rvalid on the cycle after the grant
  task automatic a_data(input logic we, input logic [AW-1:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    a_dreq = 1'b1; a_dwe = we; a_daddr = addr; a_dbe = be; a_dwd = wd;
    #1 check("a_dgnt", a_dgnt, 1'b1);
    @(negedge clk);
    a_dreq = 1'b0; a_dwe = 1'b0;
    #1 check("a_drvalid", a_drv, 1'b1);
    rd = a_drd;
  endtask

  task automatic a_fetch(input logic [AW-1:0] addr, input logic [127:0] exp);
    @(negedge clk);
    a_ireq = 1'b1; a_iaddr = addr;
    #1 check("a_igt", a_igt, 1'b1);
    @(negedge clk);
    a_ireq = 1'b0;
    #1 check("a_irvalid", a_irv, 1'b1);
    check("a_irdata", a_ird, exp);
  endtask

  // Data transaction on B with a bounded wait for rvalid and a latency check
  task automatic b_data(input logic we, input logic [AW-1:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int exp_lat, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    b_dreq = 1'b1; b_dwe = we; b_daddr = addr; b_dbe = be; b_dwd = wd;
    #1 check("b_dgnt", b_dgnt, 1'b1);
    @(negedge clk);
    b_dreq = 1'b0; b_dwe = 1'b0;
    lat = 1;
    #1;
    while (!b_drv && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    check("b_dlat", lat, exp_lat);
    rd = b_drd;
  endtask

  task automatic b_fetch(input logic [AW-1:0] addr, input int exp_lat, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    b_ireq = 1'b1; b_iaddr = addr;
    #1 check("b_igt", b_igt, 1'b1);
    @(negedge clk);
    b_ireq = 1'b0;
    lat = 1;
    #1;
    while (!b_irv && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    check("b_ilat", lat, exp_lat);
    check("b_irdata", b_ird, exp);
  endtask

  initial begin
    logic [31:0]   rd;
    logic [127:0]  exp128;
    logic [AW-1:0] fa [4];
    logic          seen;

    a_rstn = 1'b0; a_ireq = 1'b1; a_iaddr = '0; a_dreq = 1'b1; a_dwe = 1'b0;
    a_daddr = '0; a_dbe = '0; a_dwd = '0;
    b_rstn = 1'b0; b_ireq = 1'b1; b_iaddr = '0; b_dreq = 1'b1; b_dwe = 1'b0;
    b_daddr = '0; b_dbe = '0; b_dwd = '0;

    // Reset state, with requests held high to show grants are suppressed
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_igt", a_igt, 1'b0);
    check("rst_a_dgnt", a_dgnt, 1'b0);
    check("rst_a_irv", a_irv, 1'b0);
    check("rst_a_drv", a_drv, 1'b0);
    check("rst_a_ird", a_ird, 128'h0);
    check("rst_a_drd", a_drd, 32'h0);
    check("rst_a_mv", a_mv, 1'b0);
    check("rst_a_mx", a_mx, 1'b0);
    check("rst_b_igt", b_igt, 1'b0);
    check("rst_b_dgnt", b_dgnt, 1'b0);

    @(negedge clk);
    a_rstn = 1'b1; b_rstn = 1'b1;
    a_ireq = 1'b0; a_dreq = 1'b0; b_ireq = 1'b0; b_dreq = 1'b0;

    // Back-to-back 128-bit fetches of words 0x20..0x23
    a_data(1'b1, 22'h80, 4'hF, 32'hDEADBEEF, rd);
    check("a_wr_rdata_zero", rd, 32'h0);
    a_data(1'b1, 22'h84, 4'hF, 32'h01234567, rd);
    a_data(1'b1, 22'h88, 4'hF, 32'h89ABCDEF, rd);
    a_data(1'b1, 22'h8C, 4'hF, 32'hCAFEF00D, rd);
    exp128 = {32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
    fa[0] = 22'h80; fa[1] = 22'h80; fa[2] = 22'h84; fa[3] = 22'h8F;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_ireq = 1'b1; a_iaddr = fa[i];
      #1 check("a_b2b_gnt", a_igt, 1'b1);
      if (i > 0) begin
        check("a_b2b_rvalid", a_irv, 1'b1);
        check("a_b2b_rdata", a_ird, exp128);
      end
      @(negedge clk);
    end
    a_ireq = 1'b0;
    #1 check("a_b2b_last_rvalid", a_irv, 1'b1);
    check("a_b2b_last_rdata", a_ird, exp128);
    @(negedge clk);
    #1 check("a_idle_rvalid", a_irv, 1'b0);
    check("a_idle_rdata", a_ird, 128'h0);

    // Byte-enabled write over all-ones, read back with an unaligned address
    a_data(1'b1, 22'h200, 4'hF, 32'hFFFFFFFF, rd);
    a_data(1'b1, 22'h200, 4'b0101, 32'h11223344, rd);
    check("a_be_wr_rdata", rd, 32'h0);
    a_data(1'b0, 22'h203, 4'h0, 32'h0, rd);
    check("a_be_read", rd, 32'hFF22FF44);

    // Same-cycle fetch and data write to word 0x40: fetch sees the old value
    a_data(1'b1, 22'h100, 4'hF, 32'h1, rd);
    a_data(1'b1, 22'h104, 4'hF, 32'h5, rd);
    a_data(1'b1, 22'h108, 4'hF, 32'h6, rd);
    a_data(1'b1, 22'h10C, 4'hF, 32'h7, rd);
    @(negedge clk);
    a_ireq = 1'b1; a_iaddr = 22'h100;
    a_dreq = 1'b1; a_dwe = 1'b1; a_daddr = 22'h100; a_dbe = 4'hF; a_dwd = 32'h2;
    #1 check("a_col_igt", a_igt, 1'b1);
    check("a_col_dgnt", a_dgnt, 1'b1);
    @(negedge clk);
    a_ireq = 1'b0; a_dreq = 1'b0; a_dwe = 1'b0;
    #1 check("a_col_irv", a_irv, 1'b1);
    check("a_col_old", a_ird, {32'h7, 32'h6, 32'h5, 32'h1});
    check("a_col_drv", a_drv, 1'b1);
    a_fetch(22'h100, {32'h7, 32'h6, 32'h5, 32'h2});

    // Console/exit register at the top data word
    a_data(1'b1, 22'h3FFFFC, 4'hF, 32'h0, rd);
    @(negedge clk);
    a_dreq = 1'b1; a_dwe = 1'b1; a_daddr = 22'h3FFFFC; a_dbe = 4'b0011; a_dwd = 32'h141;
    #1 check("mmio_gnt", a_dgnt, 1'b1);
`ifdef MEM_MMIO_EN
    check("mmio_wvalid", a_mv, 1'b1);
    check("mmio_wdata", a_md, 8'h41);
`else
    check("mmio_wvalid_off", a_mv, 1'b0);
    check("mmio_wdata_off", a_md, 8'h00);
`endif
    @(negedge clk);
    a_dreq = 1'b0; a_dwe = 1'b0;
    #1 check("mmio_rvalid", a_drv, 1'b1);
    check("mmio_wr_rdata", a_drd, 32'h0);
    check("mmio_pulse_end", a_mv, 1'b0);
    repeat (3) @(negedge clk);
    #1;
`ifdef MEM_MMIO_EN
    check("mmio_exit_held", a_mx, 1'b1);
`else
    check("mmio_exit_off", a_mx, 1'b0);
`endif
    a_data(1'b0, 22'h3FFFFC, 4'h0, 32'h0, rd);
`ifdef MEM_MMIO_EN
    check("mmio_read_zero", rd, 32'h0);
`else
    check("mmio_addr_is_ram", rd, 32'h00000141);
`endif

    // Instance B: data latency 3
    b_data(1'b1, 22'h100, 4'hF, 32'hA5A50001, 3, rd);
    check("b_wr_rdata", rd, 32'h0);
    @(negedge clk);
    b_dreq = 1'b1; b_dwe = 1'b0; b_daddr = 22'h100;
    #1 check("b_lat_gnt_n", b_dgnt, 1'b1);
    @(negedge clk);
    #1 check("b_lat_gnt_n1", b_dgnt, 1'b0);
    check("b_lat_rv_n1", b_drv, 1'b0);
    @(negedge clk);
    #1 check("b_lat_gnt_n2", b_dgnt, 1'b0);
    check("b_lat_rv_n2", b_drv, 1'b0);
    @(negedge clk);
    #1 check("b_lat_gnt_n3", b_dgnt, 1'b1);
    check("b_lat_rv_n3", b_drv, 1'b1);
    check("b_lat_rd_n3", b_drd, 32'hA5A50001);
    b_dreq = 1'b0;
    @(negedge clk);
    #1 check("b_lat_rv_n4", b_drv, 1'b0);
    check("b_lat_rd_n4", b_drd, 32'h0);

    // Instance B: fetch latency 4, 32-bit alignment
    b_data(1'b1, 22'h200, 4'hF, 32'h600DF00D, 3, rd);
    b_fetch(22'h202, 4, 32'h600DF00D);

    // Reset two cycles after an accept drops the response
    @(negedge clk);
    b_ireq = 1'b1; b_iaddr = 22'h200;
    #1 check("b_rst_acc_gnt", b_igt, 1'b1);
    @(negedge clk);
    b_ireq = 1'b0;
    @(negedge clk);
    b_rstn = 1'b0; b_ireq = 1'b1;
    @(negedge clk);
    #1 check("b_rst_gnt", b_igt, 1'b0);
    check("b_rst_irv", b_irv, 1'b0);
    check("b_rst_ird", b_ird, 32'h0);
    b_rstn = 1'b1; b_ireq = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1 if (b_irv) seen = 1'b1;
    end
    check("b_rst_no_rvalid", seen, 1'b0);
    b_fetch(22'h200, 4, 32'h600DF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_wrap.md
# mem_wrap

Parametrised single-clock memory subsystem for the RI5CY Verilator model, sitting between `riscv_core` and the testbench. It provides an instruction fetch port and a data port on one shared word array. Fetch width and per-port response latency are configurable, and the block supports back-to-back requests. An optional memory-mapped console/exit register lets test programs print characters and terminate.

## Interface
Parameters:
- `ADDR_WIDTH`, 22: byte-address width of both ports; array depth is 2**(ADDR_WIDTH-2) 32-bit words.
- `INSTR_RDATA_WIDTH`, 128: fetch width; legal values 32, 64, 128; any other value is an elaboration error.
- `INSTR_LATENCY`, 1: cycles from instruction grant to `instr_rvalid_o`; must be ≥1 (elaboration error otherwise).
- `DATA_LATENCY`, 1: cycles from data grant to `data_rvalid_o`; must be ≥1.

Ports:
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset; synchronous, active-low.
- `instr_req_i` / `instr_gnt_o` / `instr_rvalid_o`  in/out/out  1  fetch handshake.
- `instr_addr_i`  in  ADDR_WIDTH  fetch byte address.
- `instr_rdata_o`  out  INSTR_RDATA_WIDTH  fetch data, lowest word in bits [31:0].
- `data_req_i` / `data_gnt_o` / `data_rvalid_o`  in/out/out  1  data handshake.
- `data_addr_i`  in  ADDR_WIDTH  data byte address.
- `data_we_i`  in  1  1 = write.
- `data_be_i`  in  4  byte enables.
- `data_wdata_i`  in  32  write data.
- `data_rdata_o`  out  32  read data.
- `mmio_wvalid_o`  out  1  one-cycle pulse on a console write.
- `mmio_wdata_o`  out  8  console character.
- `mmio_exit_o`  out  1  sticky; set by an exit write.

## Operation
- Each port has its own handshake FSM with states IDLE, WAIT and RESP, and at most one outstanding request.
- `gnt = req & (state==IDLE | (state==RESP))`.
  - This is combinational.
  - It is forced to 0 while `rstn_i`=0.
- On accept (`req & gnt`):
  - the counter loads LATENCY-1;
  - the next state is RESP if LATENCY=1, otherwise WAIT.
- WAIT decrements the counter and moves to RESP when the counter reaches 1.
- RESP asserts `rvalid` for exactly one cycle. The next state is:
  - IDLE if there is no accept that cycle;
  - WAIT or RESP if there is an accept.
- Read data is sampled from the array in the accept cycle and held in a response register until the `rvalid` cycle. `rdata` is 0 outside `rvalid` cycles.
- Fetch behaviour:
  - The address is aligned down to INSTR_RDATA_WIDTH/8 bytes.
  - The fetch returns INSTR_RDATA_WIDTH/32 consecutive words.
- Data behaviour:
  - `data_addr_i[1:0]` is ignored.
  - A write updates only the lanes with `be`=1, at the end of the accept cycle.
  - A write also produces `rvalid`, with `rdata` = 0.
- Simultaneous fetch accept and data write to the same word: the read samples before the write, so the fetch returns the old data.
- Array contents are not reset; the testbench preloads them.

## Timing
- Reset values:
  - all `gnt`, `rvalid`, `mmio_wvalid_o` and `mmio_exit_o` are 0;
  - all `rdata` outputs are 0;
  - both FSMs are IDLE.
- Reset asserted mid-transaction drops the pending response; no `rvalid` follows.
- Latency: an accept at cycle N gives `rvalid` at N+LATENCY.
- Throughput: a new accept is possible at N+LATENCY, so LATENCY=1 sustains one transfer per cycle.
- The two ports are fully independent: no arbitration and no mutual stalls.

## Configuration
- `MEM_MMIO_EN` defined:
  - The word at data byte address 2**ADDR_WIDTH-4 is a device register, not RAM.
  - A write with `be[0]`=1 pulses `mmio_wvalid_o` in the accept cycle, with `mmio_wdata_o` = `wdata[7:0]`.
  - A write with `be[1]`=1 and `wdata[8]`=1 sets `mmio_exit_o` until reset.
  - Reads of the register return 0.
  - The handshake and latency are unchanged.
- `MEM_MMIO_EN` undefined:
  - That address is ordinary RAM.
  - The mmio ports are tied to 0.

## Structure
- `mem_wrap_pkg` holds:
  - the port-FSM state enum (IDLE, WAIT, RESP);
  - the MMIO word-offset constant;
  - the legal-width check function.
- Sub-module `mem_wrap_port` contains the handshake FSM, latency counter and response register. It is instantiated twice, once with width INSTR_RDATA_WIDTH and once with width 32.
- The array and MMIO decode live in the `mem_wrap` top level.

## Test plan
- Defaults, preload word 0x20=0xDEADBEEF, fetch 0x80 held high for 4 cycles → grant every cycle, `rvalid` each following cycle, `instr_rdata_o` = words 0x20..0x23.
- DATA_LATENCY=3: read 0x100 accepted at cycle 10 → `data_gnt_o` low in cycles 11–12, `rvalid` at cycle 13, next grant at cycle 13.
- Write 0x11223344 with be=4'b0101 over 0xFFFFFFFF, then read back → 0xFF22FF44; the write's `rvalid` carries `rdata` = 0.
- Same-cycle fetch and data write to word 0x40 (old value 0x1, new value 0x2) → fetch returns 0x1; a subsequent fetch returns 0x2.
- INSTR_LATENCY=4, drop `rstn_i` 2 cycles after an accept → no `instr_rvalid_o`, outputs 0, FSM IDLE.
- With `MEM_MMIO_EN`: write 0x141 to 0x3FFFFC, be=4'b0011 → one `mmio_wvalid_o` pulse with 0x41, `mmio_exit_o`=1 and held; RAM word unchanged.
